// File: rtl/strum_event_encoder.sv
// Strum-bar edge to note-event encoder: snapshots the fret chord on every strum
// edge, rejects double strums with a lockout window, and queues events in a FWFT FIFO.
module strum_event_encoder #(
    parameter int NUM_FRETS      = 5,
    parameter int LOCKOUT_CYCLES = 50,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_FRETS-1:0]        fret_db,
    input  logic                        strum_db,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [NUM_FRETS-1:0]        evt_frets,
    output logic                        evt_dir,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow,
    input  logic                        ovf_clr
);
    localparam int               PTR_W      = $clog2(FIFO_DEPTH);
    localparam logic [7:0]       LOCK_LAST  = 8'(LOCKOUT_CYCLES);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        INIT    = 2'd0,
        IDLE    = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    typedef struct packed {
        logic                 dir;
        logic [NUM_FRETS-1:0] frets;
    } evt_t;

    state_t           state, state_nxt;
    logic [7:0]       lock_cnt, lock_cnt_nxt;
    logic             strum_q;
    logic             strum_edge;
    logic             push;

    evt_t             mem [FIFO_DEPTH];
    evt_t             head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             full, pop, do_push, ovf_set;

    assign strum_edge = (strum_db != strum_q);

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= INIT;
            lock_cnt <= '0;
            strum_q  <= 1'b0;
        end else begin
            state    <= state_nxt;
            lock_cnt <= lock_cnt_nxt;
            strum_q  <= strum_db;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt    = state;
        lock_cnt_nxt = lock_cnt;
        push         = 1'b0;
        case (state)
            INIT: state_nxt = IDLE;
            IDLE: begin
                if (strum_edge) begin
                    push         = 1'b1;
                    state_nxt    = LOCKOUT;
                    lock_cnt_nxt = 8'd1;
                end
            end
            LOCKOUT: begin
                if (lock_cnt == LOCK_LAST) begin
                    state_nxt    = IDLE;
                    lock_cnt_nxt = '0;
                end else begin
                    lock_cnt_nxt = lock_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt    = IDLE;
                lock_cnt_nxt = '0;
            end
        endcase
    end

    // A full FIFO still accepts a push when the head is popped on the same clock.
    assign full      = (fifo_count == FULL_COUNT);
    assign evt_valid = (fifo_count != '0);
    assign pop       = evt_valid && evt_ready;
    assign do_push   = push && (!full || pop);
    assign ovf_set   = push && full && !pop;

    assign head      = mem[rd_ptr];
    assign evt_frets = evt_valid ? head.frets : '0;
    assign evt_dir   = evt_valid & head.dir;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            overflow   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;

            if (do_push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (pop && !do_push) fifo_count <= fifo_count - 1'b1;

            if (ovf_set)      overflow <= 1'b1;
            else if (ovf_clr) overflow <= 1'b0;
        end
    end

    // NOTE: storage is deliberately not reset; outputs are masked by evt_valid, so stale entries never leak.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= '{dir: strum_db, frets: fret_db};
    end

endmodule

// File: tb/tb_strum_event_encoder.sv
// Bench for strum_event_encoder: vector table, directed corner sequences and
// randomized traffic checked every cycle against an event-queue reference model.
module tb_strum_event_encoder;
    localparam int NUM_FRETS      = 5;
    localparam int LOCKOUT_CYCLES = 50;
    localparam int FIFO_DEPTH     = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM_FRETS-1:0] fret_db = '0;
    logic                 strum_db = 1'b0;
    logic                 evt_ready = 1'b0;
    logic                 ovf_clr = 1'b0;
    logic                 evt_valid;
    logic [NUM_FRETS-1:0] evt_frets;
    logic                 evt_dir;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                 overflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    strum_event_encoder #(
        .NUM_FRETS(NUM_FRETS), .LOCKOUT_CYCLES(LOCKOUT_CYCLES), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .fret_db(fret_db), .strum_db(strum_db),
        .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_frets(evt_frets),
        .evt_dir(evt_dir), .fifo_count(fifo_count), .overflow(overflow), .ovf_clr(ovf_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: an event is accepted if it is a level change, not on the
    // first clock after reset, and more than LOCKOUT_CYCLES clocks after the last one.
    typedef struct packed {
        logic                 dir;
        logic [NUM_FRETS-1:0] frets;
    } m_evt_t;

    m_evt_t mq[$];
    bit     m_ovf, m_first, m_have;
    longint m_cyc, m_last;
    logic   m_prev;

    always @(posedge clk or negedge rst) begin
        bit     m_pop, m_acc, m_set;
        m_evt_t e;
        if (!rst) begin
            mq.delete();
            m_ovf = 0; m_first = 1; m_have = 0; m_cyc = 0; m_last = 0; m_prev = 1'b0;
        end else begin
            m_cyc++;
            m_pop = (mq.size() > 0) && evt_ready;
            m_acc = !m_first && (strum_db != m_prev) &&
                    (!m_have || (m_cyc - m_last) > LOCKOUT_CYCLES);
            if (m_pop) void'(mq.pop_front());
            m_set = 0;
            if (m_acc) begin
                m_have = 1;
                m_last = m_cyc;
                e.dir   = strum_db;
                e.frets = fret_db;
                if (mq.size() < FIFO_DEPTH) mq.push_back(e);
                else m_set = 1;
            end
            if (m_set) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
            m_prev  = strum_db;
            m_first = 0;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            check("model_valid", evt_valid, mq.size() > 0);
            check("model_frets", evt_frets, (mq.size() > 0) ? mq[0].frets : '0);
            check("model_dir",   evt_dir,   (mq.size() > 0) ? mq[0].dir : 1'b0);
            check("model_count", fifo_count, mq.size());
            check("model_ovf",   overflow,  m_ovf);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input logic strum_lvl);
        rst = 1'b0; strum_db = strum_lvl; fret_db = '0; evt_ready = 1'b0; ovf_clr = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic strum(input logic [NUM_FRETS-1:0] frets, input logic rdy);
        fret_db = frets; strum_db = ~strum_db; evt_ready = rdy;
        tick();
    endtask

    typedef struct {
        logic [NUM_FRETS-1:0] fret;
        logic strum, ready, clr;
        logic valid;
        logic [NUM_FRETS-1:0] efrets;
        logic edir;
        logic [3:0] ecount;
        logic eovf;
    } vec_t;

    vec_t vt[5];

    initial begin
        // one row per clock, starting with the INIT clock after reset release
        vt[0] = '{5'b10101, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 4'd0, 1'b0};
        vt[1] = '{5'b10101, 1'b1, 1'b0, 1'b0, 1'b1, 5'b10101, 1'b1, 4'd1, 1'b0};
        vt[2] = '{5'b10101, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00000, 1'b0, 4'd0, 1'b0};
        vt[3] = '{5'b00011, 1'b0, 1'b0, 1'b0, 1'b0, 5'b00000, 1'b0, 4'd0, 1'b0};
        vt[4] = '{5'b00011, 1'b0, 1'b0, 1'b1, 1'b0, 5'b00000, 1'b0, 4'd0, 1'b0};

        #2;
        // Switch already high at reset release: never an event.
        do_reset(1'b1);
        for (int i = 0; i < 100; i++) begin
            tick();
            check("no_spurious_valid", evt_valid, 1'b0);
        end

        // Vector table.
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) begin
            fret_db = vt[i].fret; strum_db = vt[i].strum; evt_ready = vt[i].ready; ovf_clr = vt[i].clr;
            tick();
            check("vec_valid", evt_valid, vt[i].valid);
            check("vec_frets", evt_frets, vt[i].efrets);
            check("vec_dir",   evt_dir,   vt[i].edir);
            check("vec_count", fifo_count, vt[i].ecount);
            check("vec_ovf",   overflow,  vt[i].eovf);
        end
        ovf_clr = 1'b0; evt_ready = 1'b0;

        // Lockout boundary: edge at T+50 ignored, edge at T+51 accepted.
        do_reset(1'b0);
        tick();
        strum(5'b00001, 1'b0);
        check("lock_first_valid", evt_valid, 1'b1);
        check("lock_first_dir",   evt_dir,   1'b1);
        evt_ready = 1'b1;
        idle(LOCKOUT_CYCLES - 1);
        strum(5'b00010, 1'b1);
        check("lock_edge_ignored", evt_valid, 1'b0);
        strum(5'b00100, 1'b1);
        check("lock_after_valid", evt_valid, 1'b1);
        check("lock_after_dir",   evt_dir,   1'b1);
        check("lock_after_frets", evt_frets, 5'b00100);
        evt_ready = 1'b0;
        idle(2);

        // Fill and overflow, then drain in order.
        do_reset(1'b0);
        tick();
        for (int k = 0; k < 5; k++) begin
            strum(NUM_FRETS'(1 << k), 1'b0);
            if (k < 4) idle(59);
        end
        check("ovf_count", fifo_count, 4);
        check("ovf_set",   overflow,   1'b1);
        for (int k = 0; k < 4; k++) begin
            check("drain_valid", evt_valid, 1'b1);
            check("drain_frets", evt_frets, NUM_FRETS'(1 << k));
            check("drain_dir",   evt_dir,   (k % 2) == 0);
            evt_ready = 1'b1;
            tick();
            evt_ready = 1'b0;
        end
        check("drain_empty", evt_valid, 1'b0);
        check("drain_ovf_sticky", overflow, 1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovf_cleared", overflow, 1'b0);

        // Full FIFO: push and pop on the same clock.
        idle(60);
        strum(5'd3, 1'b0); idle(59);
        strum(5'd5, 1'b0); idle(59);
        strum(5'd6, 1'b0); idle(59);
        strum(5'd9, 1'b0); idle(59);
        check("full_count", fifo_count, 4);
        strum(5'd17, 1'b1);
        evt_ready = 1'b0;
        check("full_pp_ovf",   overflow,   1'b0);
        check("full_pp_count", fifo_count, 4);
        check("full_pp_head",  evt_frets,  5'd5);
        evt_ready = 1'b1;
        tick(); check("full_pp_next1", evt_frets, 5'd6);
        tick(); check("full_pp_next2", evt_frets, 5'd9);
        tick(); check("full_pp_tail",  evt_frets, 5'd17);
        tick(); check("full_pp_empty", evt_valid, 1'b0);
        evt_ready = 1'b0;

        // Asynchronous reset mid-lockout with two buffered events.
        do_reset(1'b0);
        tick();
        strum(5'd1, 1'b0); idle(59);
        strum(5'd2, 1'b0); idle(10);
        check("pre_rst_count", fifo_count, 2);
        rst = 1'b0;
        strum_db = 1'b1;
        #1;
        check("async_rst_valid", evt_valid, 1'b0);
        check("async_rst_count", fifo_count, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        check("init_edge_ignored", evt_valid, 1'b0);
        strum(5'd8, 1'b0);
        check("post_rst_valid", evt_valid, 1'b1);
        check("post_rst_dir",   evt_dir,   1'b0);
        check("post_rst_frets", evt_frets, 5'd8);

        // Randomized traffic: slow consumer first (overflows), then a fast one.
        do_reset(1'b0);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) strum_db = ~strum_db;
            fret_db   = NUM_FRETS'($urandom);
            evt_ready = ($urandom_range(0, (i < 1500) ? 255 : 3) == 0);
            ovf_clr   = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b0;
                tick();
                rst = 1'b1;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/strum_event_encoder.md
Name: strum_event_encoder

Overview:
Consumes the debounced fret and strum switch levels and turns each strum-bar movement into a discrete note event. Each event carries a snapshot of the fret chord and the strum direction. A lockout window rejects double strums. Events are buffered in a small first-word-fall-through (FWFT) FIFO and offered to the downstream note-judging logic over a valid/ready handshake.

Parameters:
NUM_FRETS, 5, number of fret switch inputs and event chord width
LOCKOUT_CYCLES, 50, cycles after an accepted strum during which further strum edges are ignored (legal range 1..255; 8-bit counter)
FIFO_DEPTH, 4, event FIFO entries (power of two, >=2)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-low reset
fret_db  in  NUM_FRETS  debounced fret levels, 1 = pressed
strum_db  in  1  debounced strum switch level; every edge (either direction) is a strum
evt_valid  out  1  FIFO non-empty; head event present
evt_ready  in  1  consumer accepts head event when evt_valid=1
evt_frets  out  NUM_FRETS  chord snapshot of head event; 0 when empty
evt_dir  out  1  head event direction: 1 = rising edge (down-strum), 0 = falling edge (up-strum); 0 when empty
fifo_count  out  clog2(FIFO_DEPTH)+1  occupied entries, 0..FIFO_DEPTH
overflow  out  1  sticky: an accepted strum was dropped because the FIFO was full
ovf_clr  in  1  synchronous clear of overflow

Behaviour:
- Reset is asynchronous, active-low. Reset is decided as: reset rst, asynchronous, active-low; clock clk.
- Reset values:
  - state = INIT, strum_q = 0, lockout count = 0
  - FIFO pointers = 0, fifo_count = 0
  - evt_valid = 0, evt_frets = 0, evt_dir = 0, overflow = 0
- Edge detect: strum_q is a register of strum_db. Edge = (strum_db != strum_q), sampled at each clk rising edge. strum_q updates every cycle in every state.
- FSM states:
  - INIT: first clock after reset release. Loads strum_q, generates no event, goes to IDLE. A switch already high at reset release therefore produces no spurious strum.
  - IDLE: an edge is accepted. Push {dir = strum_db, frets = fret_db sampled on the same clock} and go to LOCKOUT with count = 1. No edge: stay in IDLE.
  - LOCKOUT: edges are ignored, with no push and no overflow. count increments each clock. When count == LOCKOUT_CYCLES, go to IDLE and reset count to 0.
  - Net effect: an edge accepted at clock T blocks edges sampled at T+1..T+LOCKOUT_CYCLES; an edge at T+LOCKOUT_CYCLES+1 is accepted.
  - Illegal state encodings recover to IDLE on the next clock.
- An open strum (fret_db = 0) is a valid event.
- FIFO (FWFT):
  - The push at clock T makes evt_valid = 1 after T; the event is visible the cycle after the edge is sampled.
  - Pop occurs when evt_valid && evt_ready. Pointers wrap modulo FIFO_DEPTH.
  - Push and pop on the same clock: both happen and fifo_count is unchanged. This also applies when full, so an accepted push to a full FIFO succeeds if a pop occurs on the same clock.
  - Push to a full FIFO without a pop: the event is dropped, overflow is set, and contents are unchanged.
  - evt_ready while empty has no effect; fifo_count never underflows.
  - evt_frets and evt_dir hold stable while evt_valid=1 and evt_ready=0.
- overflow:
  - ovf_clr=1 clears it.
  - If a set and a clear occur on the same clock, set wins.
- Reset asserted mid-operation: all state returns to reset values immediately; buffered events are discarded.

Test Plan:
- Reset release with strum_db=1 held, fret_db=5'b00000 -> no event ever; evt_valid stays 0 for 100 cycles.
- IDLE, fret_db=5'b10101, strum_db 0->1 sampled at clock T, evt_ready=1 -> evt_valid=1 for exactly one cycle (T+1), evt_frets=5'b10101, evt_dir=1, fifo_count returns to 0.
- LOCKOUT_CYCLES=50: accepted edge at T, second edge at T+50 -> ignored (no event). Third edge at T+51 -> accepted, evt_dir matches the new level.
- evt_ready=0; 5 accepted strums spaced 60 cycles apart, chords 1,2,4,8,16 -> fifo_count=4, overflow=1 after the 5th. Popping yields 1,2,4,8 in order, then evt_valid=0. ovf_clr pulse -> overflow=0.
- FIFO full, evt_ready=1 on the same clock as an accepted edge -> no overflow, fifo_count stays 4. Head advances and the new event lands at the tail.
- Assert rst low mid-lockout with fifo_count=2 -> evt_valid=0 and fifo_count=0 asynchronously. After release, first edge in INIT is ignored; the next edge is accepted immediately (no residual lockout).
